// File: rtl/ram_dist_reader.sv
// Burst reader for a distributed RAM: walks read_address from base_address and streams words out with valid/ready.
// Define RAM_DIST_READER_LOOP_EN to add loop_enable, which repeats the burst until abort or reset.
module ram_dist_reader #(
    parameter int RAM_WIDTH     = 16,
    parameter int RAM_ADDR_BITS = 10
) (
    input  logic                     clock,
    input  logic                     reset,
`ifdef RAM_DIST_READER_LOOP_EN
    input  logic                     loop_enable,
`endif
    input  logic                     start,
    input  logic [RAM_ADDR_BITS-1:0] base_address,
    input  logic [RAM_ADDR_BITS:0]   length,
    input  logic                     abort,
    output logic [RAM_ADDR_BITS-1:0] read_address,
    input  logic [RAM_WIDTH-1:0]     ram_data,
    output logic [RAM_WIDTH-1:0]     out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    localparam logic [RAM_ADDR_BITS:0] COUNT_ONE = {{RAM_ADDR_BITS{1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    logic [RAM_ADDR_BITS:0]   count_q, count_d;
    logic [RAM_ADDR_BITS-1:0] addr_d;
    logic [RAM_WIDTH-1:0]     data_d;
    logic                     valid_d;
    logic                     done_d;

`ifdef RAM_DIST_READER_LOOP_EN
    logic [RAM_ADDR_BITS-1:0] base_q;
    logic [RAM_ADDR_BITS:0]   len_q;
    logic                     loop_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_q <= '0;
            len_q  <= '0;
            loop_q <= 1'b0;
        end else if (state_q == IDLE && start && !abort) begin
            base_q <= base_address;
            len_q  <= length;
            loop_q <= loop_enable;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            read_address <= '0;
            count_q      <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            read_address <= addr_d;
            count_q      <= count_d;
            out_data     <= data_d;
            out_valid    <= valid_d;
            done         <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = read_address;
        count_d = count_q;
        data_d  = out_data;
        valid_d = out_valid;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            valid_d = 1'b0;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            state_d = FETCH;
                            addr_d  = base_address;
                            count_d = length;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                FETCH: begin
                    // Capture into the output register whenever it is empty or being drained this cycle.
                    if (!out_valid || out_ready) begin
                        data_d  = ram_data;
                        valid_d = 1'b1;
                        addr_d  = read_address + 1'b1;
                        count_d = count_q - 1'b1;
                        if (count_q == COUNT_ONE) begin
`ifdef RAM_DIST_READER_LOOP_EN
                            if (loop_q) begin
                                addr_d  = base_q;
                                count_d = len_q;
                            end else begin
                                state_d = DRAIN;
                            end
`else
                            state_d = DRAIN;
`endif
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: doc/ram_dist_reader.md
RAM_DIST_READER -- requirements
Module: ram_dist_reader

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter RAM_ADDR_BITS, default 10, RAM address width in bits (depth 2**RAM_ADDR_BITS).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst read.
REQ-006 SHALL have port base_address  input  RAM_ADDR_BITS  first word address, sampled with start.
REQ-007 SHALL have port length  input  RAM_ADDR_BITS+1  word count 0..2**RAM_ADDR_BITS, sampled with start.
REQ-008 SHALL have port abort  input  1  terminate the current burst.
REQ-009 SHALL have port read_address  output  RAM_ADDR_BITS  registered address to the distributed RAM's asynchronous read port.
REQ-010 SHALL have port ram_data  input  RAM_WIDTH  combinational RAM read data for read_address.
REQ-011 SHALL have port out_data  output  RAM_WIDTH  stream data.
REQ-012 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-013 SHALL have port out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-014 SHALL have port busy  output  1  burst in progress (state not IDLE).
REQ-015 SHALL have port done  output  1  one-cycle pulse at burst completion.

Function
REQ-016 SHALL implement states IDLE, FETCH (words left to issue), DRAIN (all issued, last word not yet transferred).
REQ-017 IDLE -> FETCH when start=1 and length>0; read_address loads base_address, issue counter loads length.
REQ-018 start with length=0 in IDLE: no words output, done=1 the following cycle, state stays IDLE.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 In FETCH, ram_data SHALL be captured into out_data when output register empty or transferring this cycle; read_address then increments and counter decrements.
REQ-021 read_address increment SHALL wrap modulo 2**RAM_ADDR_BITS (1023 -> 0 at default).
REQ-022 Latency: start in cycle N -> read_address=base in N+1 -> out_valid=1 with word[base] in N+2.
REQ-023 Throughput SHALL be one word per cycle while out_ready=1 continuously.
REQ-024 While out_valid=1 and out_ready=0, out_data and read_address SHALL hold stable; no word dropped or duplicated.
REQ-025 FETCH -> DRAIN when the last word is captured; DRAIN -> IDLE on its transfer, done=1 in the next cycle.
REQ-026 abort=1 in any state SHALL force IDLE next cycle, out_valid=0, done not pulsed; abort has priority over start.
REQ-027 Words SHALL be output in ascending address order (with wrap), exactly length words per burst.

Reset
REQ-028 reset=1 SHALL asynchronously force IDLE, read_address=0, out_data=0, out_valid=0, busy=0, done=0, counter=0.
REQ-029 reset asserted mid-burst SHALL discard the burst; no done pulse after release.
REQ-030 First start SHALL be honoured in the first clock edge after reset deasserts.

Configuration
REQ-031 Macro RAM_DIST_READER_LOOP_EN SHALL, when defined, add input port loop_enable (1 bit), sampled with start.
REQ-032 With RAM_DIST_READER_LOOP_EN defined and loop_enable=1: after the last word of a pass is captured, read_address reloads base_address, counter reloads length, reading continues without a bubble; done never pulses; only abort or reset ends the burst.
REQ-033 With RAM_DIST_READER_LOOP_EN undefined: port loop_enable absent; every burst is single-pass per REQ-025.

Verification
REQ-034 RAM preloaded word[i]=i; start, base=5, length=4, out_ready=1 -> out_data 5,6,7,8 on consecutive cycles starting 2 cycles after start, done one cycle after last.
REQ-035 base=1022, length=4 -> out_data sequence 1022,1023,0,1 (wrap).
REQ-036 length=4, out_ready toggling 1,0,0,1,... -> out_data stable during stalls, exactly 4 transfers, values 5..8 in order.
REQ-037 start with length=0 -> no out_valid, done=1 exactly one cycle later; start during busy -> ignored, burst unchanged.
REQ-038 abort asserted after 2 transfers of length=8 -> out_valid=0, busy=0 next cycle, no done; reset mid-burst -> all outputs 0 immediately.
REQ-039 With RAM_DIST_READER_LOOP_EN, loop_enable=1, base=0, length=3 -> stream 0,1,2,0,1,2,... gap-free until abort, no done.
